// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the PC sequencer: instruction codes, status
// encodings, sequencer states and the memory-operation decode.
package y86_pkg;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        SAOK = 2'd0,
        SHLT = 2'd1,
        SADR = 2'd2,
        SINS = 2'd3
    } stat_e;

    // Encodings 0..4 double as the stage_en bit index.
    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StPcUpdate  = 3'd5,
        StHalted    = 3'd6
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] icode);
        return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

endpackage

// File: rtl/pc_select.sv
// Next-PC selection: call and taken jump go to valC, return to valM,
// everything else falls through to valP.
module pc_select
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] new_pc
);

    always_comb begin
        new_pc = valP;
        if (icode == ICALL || (icode == IJXX && cnd)) begin
            new_pc = valC;
        end else if (icode == IRET) begin
            new_pc = valM;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle Y86-64 sequencer: steps the five stages plus a PC-update cycle.
// Define IMEM_BOUNDS_CHECK_EN to halt with ADR when fetching at PC >= IMEM_LIMIT.
module pc_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] START_PC   = 64'h0,
    parameter logic [63:0] IMEM_LIMIT = 64'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        mem_ack,
    input  logic        dmem_error,
    output logic [63:0] PC,
    output logic [4:0]  stage_en,
    output logic        mem_req,
    output logic [1:0]  stat,
    output logic        halted,
    output logic [31:0] instr_count
);

    state_e      state_q, state_d;
    stat_e       stat_q, stat_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [3:0]  icode_q, icode_d;
    logic [63:0] new_pc;

    pc_select u_pc_select (
        .icode  (icode_q),
        .cnd    (cnd),
        .valC   (valC),
        .valP   (valP),
        .valM   (valM),
        .new_pc (new_pc)
    );

`ifndef IMEM_BOUNDS_CHECK_EN
    logic unused_imem_limit;
    assign unused_imem_limit = ^IMEM_LIMIT;
`endif

    // run=0 leaves every *_d at its *_q, which freezes the machine.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        pc_d    = pc_q;
        count_d = count_q;
        icode_d = icode_q;
        if (run) begin
            unique case (state_q)
                StFetch: begin
                    icode_d = icode;
`ifdef IMEM_BOUNDS_CHECK_EN
                    if (pc_q >= IMEM_LIMIT) begin
                        stat_d  = SADR;
                        state_d = StHalted;
                    end else
`endif
                    if (!instr_valid) begin
                        stat_d  = SINS;
                        state_d = StHalted;
                    end else if (icode == IHALT) begin
                        stat_d  = SHLT;
                        state_d = StHalted;
                        count_d = count_q + 32'd1;
                    end else begin
                        state_d = StDecode;
                    end
                end
                StDecode:  state_d = StExecute;
                StExecute: state_d = StMemory;
                StMemory: begin
                    if (!is_mem_op(icode_q)) begin
                        state_d = StWriteback;
                    end else if (mem_ack) begin
                        if (dmem_error) begin
                            stat_d  = SADR;
                            state_d = StHalted;
                        end else begin
                            state_d = StWriteback;
                        end
                    end
                end
                StWriteback: state_d = StPcUpdate;
                StPcUpdate: begin
                    pc_d    = new_pc;
                    count_d = count_q + 32'd1;
                    state_d = StFetch;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            stat_q  <= SAOK;
            pc_q    <= START_PC;
            count_q <= '0;
            icode_q <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            icode_q <= icode_d;
        end
    end

    always_comb begin
        stage_en = '0;
        if (run) begin
            unique case (state_q)
                StFetch:     stage_en = 5'b00001;
                StDecode:    stage_en = 5'b00010;
                StExecute:   stage_en = 5'b00100;
                StMemory:    stage_en = 5'b01000;
                StWriteback: stage_en = 5'b10000;
                default:     stage_en = '0;
            endcase
        end
    end

    assign mem_req     = (state_q == StMemory) && is_mem_op(icode_q);
    assign halted      = (state_q == StHalted);
    assign PC          = pc_q;
    assign stat        = stat_q;
    assign instr_count = count_q;

endmodule
